ce_period_meter: RTL

Receive-side checker for the periodic clock-enable strobe produced by the millisecond tick generator. It measures the spacing of incoming single-cycle `ce_in` pulses in `clk` cycles and reports each measured period. It flags strobes that arrive outside a tolerance window and strobes that fail to arrive at all, and asserts `locked` once the tick train is stable. It sits beside any consumer of the 1 ms tick and serves as a timebase watchdog and debug aid.

---
 rtl/ce_period_meter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ce_period_meter.sv
// Clock-enable strobe period meter: measures ce_in spacing, flags short/missing strobes, reports lock.
// Optional saturating error counter enabled by defining CEPM_ERRCNT_EN.
//
// state      | meaning
// WAIT_FIRST | no reference strobe yet; counter idle
// MEASURE    | counting cycles since the last strobe
module ce_period_meter #(
    parameter int FCLK   = 50000000,
    parameter int FTICK  = 1000,
    parameter int TOL    = 16,
    parameter int LOCK_N = 4,
    parameter int CW     = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce_in,
    output logic [CW-1:0] period,
    output logic          period_vld,
    output logic          err_period,
    output logic          err_missing,
    output logic          locked,
    output logic [7:0]    err_count
);

    localparam int NOM = FCLK / FTICK;
    localparam logic [CW-1:0] LO = CW'(NOM - TOL);
    localparam logic [CW-1:0] HI = CW'(NOM + TOL);
    localparam logic [4:0] LOCK_V = 5'(LOCK_N);

    typedef enum logic {WAIT_FIRST = 1'b0, MEASURE = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic          period_vld_q, period_vld_d;
    logic          err_period_q, err_period_d;
    logic          err_missing_q, err_missing_d;
    logic          locked_q, locked_d;
    logic [3:0]    run_q, run_d;
    logic [4:0]    run_inc;

    assign run_inc = {1'b0, run_q} + 5'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        period_vld_d  = 1'b0;
        err_period_d  = 1'b0;
        err_missing_d = 1'b0;
        locked_d      = locked_q;
        run_d         = run_q;
        case (state_q)
            WAIT_FIRST: begin
                if (ce_in) begin
                    cnt_d   = CW'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (ce_in) begin
                    // Strobe wins over timeout, so cnt_q==HI here is still in window.
                    period_d     = cnt_q;
                    period_vld_d = 1'b1;
                    cnt_d        = CW'(1);
                    if (cnt_q >= LO && cnt_q <= HI) begin
                        if (run_inc <= LOCK_V) begin
                            run_d = run_inc[3:0];
                        end
                        if (run_inc >= LOCK_V) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        err_period_d = 1'b1;
                        locked_d     = 1'b0;
                        run_d        = 4'd0;
                    end
                end else if (cnt_q == HI) begin
                    err_missing_d = 1'b1;
                    locked_d      = 1'b0;
                    run_d         = 4'd0;
                    cnt_d         = '0;
                    state_d       = WAIT_FIRST;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_FIRST;
            cnt_q         <= '0;
            period_q      <= '0;
            period_vld_q  <= 1'b0;
            err_period_q  <= 1'b0;
            err_missing_q <= 1'b0;
            locked_q      <= 1'b0;
            run_q         <= 4'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            period_vld_q  <= period_vld_d;
            err_period_q  <= err_period_d;
            err_missing_q <= err_missing_d;
            locked_q      <= locked_d;
            run_q         <= run_d;
        end
    end

    assign period      = period_q;
    assign period_vld  = period_vld_q;
    assign err_period  = err_period_q;
    assign err_missing = err_missing_q;
    assign locked      = locked_q;

`ifdef CEPM_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Counts alongside the error pulse so the count is current when the pulse is seen.
    always_comb begin
        err_count_d = err_count_q;
        if ((err_period_d || err_missing_d) && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'd0;
`endif

endmodule
